// File: rtl/id_pkg.sv
// Shared decode definitions for the ID stage: instruction field positions,
// the NOP opcode, the writes-rd predicate and the EX control record.
package id_pkg;

  localparam int unsigned OP_HI  = 31;
  localparam int unsigned OP_LO  = 26;
  localparam int unsigned RD_HI  = 25;
  localparam int unsigned RD_LO  = 22;
  localparam int unsigned RA_HI  = 21;
  localparam int unsigned RA_LO  = 18;
  localparam int unsigned RB_HI  = 17;
  localparam int unsigned RB_LO  = 14;
  localparam int unsigned IMM_HI = 13;
  localparam int unsigned IMM_LO = 0;
  localparam int unsigned IMM_W  = IMM_HI - IMM_LO + 1;

  localparam logic [5:0] OP_NOP = 6'h00;

  typedef struct packed {
    logic [5:0] op;
    logic [3:0] rd;
    logic       wr;
  } id_dec_t;

  // Opcodes 0x01-0x1F write rd; r0 is never a real destination.
  function automatic logic writes_rd(input logic [5:0] op, input logic [3:0] rd);
    return (op != OP_NOP) && !op[5] && (rd != 4'd0);
  endfunction

endpackage

// File: rtl/id_stage_if.sv
// ID stage bus: IF-side instruction, WB-side write port, stall back to IF
// and the registered EX-side outputs.
interface id_stage_if #(parameter int DW = 16);

  logic [31:0]   IR2;
  logic [DW-1:0] PC2;
  logic          jmp;
  logic          wb_en;
  logic [3:0]    wb_addr;
  logic [DW-1:0] wb_data;
  logic          stall;
  logic [5:0]    OP3;
  logic [3:0]    RD3;
  logic          WR3;
  logic [DW-1:0] A3;
  logic [DW-1:0] B3;
  logic [DW-1:0] IMM3;
  logic [DW-1:0] PC3;

  modport master (
    output IR2, PC2, jmp, wb_en, wb_addr, wb_data,
    input  stall, OP3, RD3, WR3, A3, B3, IMM3, PC3
  );

  modport slave (
    input  IR2, PC2, jmp, wb_en, wb_addr, wb_data,
    output stall, OP3, RD3, WR3, A3, B3, IMM3, PC3
  );

endinterface

// File: rtl/id_regfile.sv
// 16 x DW register file, two read ports and one write port; r0 reads zero.
// ID_FORWARD_EN: same-cycle WB write data bypasses onto the read ports.
module id_regfile #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          clr,
  input  logic [3:0]    i_ra,
  input  logic [3:0]    i_rb,
  input  logic          i_we,
  input  logic [3:0]    i_wa,
  input  logic [DW-1:0] i_wd,
  output logic [DW-1:0] o_a,
  output logic [DW-1:0] o_b
);

  logic [DW-1:0] r_mem [16];

  // Entry 0 is never written; reads of r0 are forced to zero below.
  always_ff @(posedge clk) begin
    if (!clr && i_we && (i_wa != 4'd0)) begin
      r_mem[i_wa] <= i_wd;
    end
  end

  always_comb begin
    o_a = (i_ra == 4'd0) ? '0 : r_mem[i_ra];
    o_b = (i_rb == 4'd0) ? '0 : r_mem[i_rb];
`ifdef ID_FORWARD_EN
    if (i_we && (i_wa == i_ra) && (i_ra != 4'd0)) o_a = i_wd;
    if (i_we && (i_wa == i_rb) && (i_rb != 4'd0)) o_b = i_wd;
`endif
  end

endmodule

// File: rtl/id_stage.sv
// Instruction decode stage: field decode, register read, busy-bit scoreboard,
// hazard stall and the EX output register. ID_FORWARD_EN enables WB bypass.
module id_stage
  import id_pkg::*;
#(
  parameter int DW = 16
) (
  input logic       clk,
  input logic       clr,
  id_stage_if.slave bus
);

  logic [5:0]       w_op;
  logic [3:0]       w_rd;
  logic [3:0]       w_ra;
  logic [3:0]       w_rb;
  logic [IMM_W-1:0] w_imm14;
  logic [DW-1:0]    w_imm;
  logic [DW-1:0]    w_a;
  logic [DW-1:0]    w_b;
  logic [15:0]      w_busy_eff;
  logic [15:0]      w_busy_next;
  logic             w_stall;
  logic             w_issue;

  logic [15:0]      r_busy;
  id_dec_t          r_dec;
  logic [DW-1:0]    r_a;
  logic [DW-1:0]    r_b;
  logic [DW-1:0]    r_imm;
  logic [DW-1:0]    r_pc;

  assign w_op    = bus.IR2[OP_HI:OP_LO];
  assign w_rd    = bus.IR2[RD_HI:RD_LO];
  assign w_ra    = bus.IR2[RA_HI:RA_LO];
  assign w_rb    = bus.IR2[RB_HI:RB_LO];
  assign w_imm14 = bus.IR2[IMM_HI:IMM_LO];
  assign w_imm   = {{(DW-IMM_W){w_imm14[IMM_W-1]}}, w_imm14};

  id_regfile #(.DW(DW)) u_regfile (
    .clk  (clk),
    .clr  (clr),
    .i_ra (w_ra),
    .i_rb (w_rb),
    .i_we (bus.wb_en),
    .i_wa (bus.wb_addr),
    .i_wd (bus.wb_data),
    .o_a  (w_a),
    .o_b  (w_b)
  );

  // With bypass, a register being written back this cycle is already readable.
  always_comb begin
    w_busy_eff = r_busy;
`ifdef ID_FORWARD_EN
    if (bus.wb_en) w_busy_eff[bus.wb_addr] = 1'b0;
`endif
  end

  assign w_stall   = !bus.jmp && (w_op != OP_NOP) &&
                     (w_busy_eff[w_ra] || w_busy_eff[w_rb]);
  assign w_issue   = !bus.jmp && !w_stall;
  assign bus.stall = w_stall;

  // Clear first, then set, so an issuing writer wins over a same-register writeback.
  always_comb begin
    w_busy_next = r_busy;
    if (bus.wb_en) w_busy_next[bus.wb_addr] = 1'b0;
    if (w_issue && writes_rd(w_op, w_rd)) w_busy_next[w_rd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      r_busy <= '0;
      r_dec  <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_imm  <= '0;
      r_pc   <= '0;
    end else begin
      r_busy <= w_busy_next;
      if (w_issue) begin
        r_dec.op <= w_op;
        r_dec.rd <= w_rd;
        r_dec.wr <= writes_rd(w_op, w_rd);
        r_a      <= w_a;
        r_b      <= w_b;
        r_imm    <= w_imm;
        r_pc     <= bus.PC2;
      end else begin
        r_dec <= '0;
        r_a   <= '0;
        r_b   <= '0;
        r_imm <= '0;
        r_pc  <= '0;
      end
    end
  end

  assign bus.OP3  = r_dec.op;
  assign bus.RD3  = r_dec.rd;
  assign bus.WR3  = r_dec.wr;
  assign bus.A3   = r_a;
  assign bus.B3   = r_b;
  assign bus.IMM3 = r_imm;
  assign bus.PC3  = r_pc;

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed scenarios plus randomized traffic
// against a behavioural scoreboard/register-file model.
module tb_id_stage;

  localparam int DW = 16;
`ifdef ID_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  id_stage_if #(.DW(DW)) bus ();
  id_stage #(.DW(DW)) dut (.clk(clk), .clr(clr), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] m_rf [16];
  bit            m_busy [16];
  logic          got_stall;
  bit            exp_stall;
  logic [5:0]    e_op;
  logic [3:0]    e_rd;
  logic          e_wr;
  logic [DW-1:0] e_a, e_b, e_imm, e_pc;

  function automatic logic [31:0] mk(input int op, input int rd, input int ra,
                                     input int rb, input int imm);
    return {op[5:0], rd[3:0], ra[3:0], rb[3:0], imm[13:0]};
  endfunction

  function automatic logic [DW-1:0] m_read(input int x);
    if (x == 0) return '0;
    if (FWD && bus.wb_en && (int'(bus.wb_addr) == x)) return bus.wb_data;
    return m_rf[x];
  endfunction

  function automatic bit m_is_busy(input int x);
    return m_busy[x] && !(FWD && bus.wb_en && (int'(bus.wb_addr) == x));
  endfunction

  // One clock: drive inputs, predict, sample stall mid-cycle, step the model.
  task automatic cycle(input logic [31:0] ir, input logic [DW-1:0] pc, input bit j,
                       input bit we, input int wa, input logic [DW-1:0] wd, input bit c);
    int op, rd, ra, rb, v;
    bit issue;
    bus.IR2 = ir; bus.PC2 = pc; bus.jmp = j;
    bus.wb_en = we; bus.wb_addr = wa[3:0]; bus.wb_data = wd; clr = c;
    op = int'(ir[31:26]); rd = int'(ir[25:22]); ra = int'(ir[21:18]); rb = int'(ir[17:14]);
    exp_stall = !j && (op != 0) && (m_is_busy(ra) || m_is_busy(rb));
    issue = !j && !exp_stall;
    if (c || !issue) begin
      e_op = '0; e_rd = '0; e_wr = 1'b0; e_a = '0; e_b = '0; e_imm = '0; e_pc = '0;
    end else begin
      e_op = op[5:0]; e_rd = rd[3:0];
      e_wr = (op >= 1) && (op <= 31) && (rd != 0);
      e_a = m_read(ra); e_b = m_read(rb);
      v = int'(ir[13:0]);
      if (v >= 8192) v = v - 16384;
      e_imm = v[DW-1:0]; e_pc = pc;
    end
    #3;
    got_stall = bus.stall;
    @(posedge clk);
    #1;
    if (c) begin
      foreach (m_busy[i]) m_busy[i] = 1'b0;
    end else begin
      if (we && wa != 0) m_rf[wa] = wd;
      if (we) m_busy[wa] = 1'b0;
      if (issue && e_wr) m_busy[rd] = 1'b1;
    end
  endtask

  task automatic test_reset();
    cycle(32'h0, '0, 1'b1, 1'b1, 9, 16'h5555, 1'b1);
    cycle(32'h0, '0, 1'b0, 1'b0, 0, '0, 1'b1);
    n_tests++;
    if ({bus.OP3, bus.RD3, bus.WR3, bus.A3, bus.B3, bus.IMM3, bus.PC3} !== '0) begin
      n_fail++; $display("FAIL reset_outputs got op=%h a=%h pc=%h exp all zero", bus.OP3, bus.A3, bus.PC3);
    end
    n_tests++;
    if (got_stall !== 1'b0) begin
      n_fail++; $display("FAIL reset_stall got=%b exp=0", got_stall);
    end
    for (int r = 1; r < 16; r++) cycle(32'h0, '0, 1'b0, 1'b1, r, DW'($urandom), 1'b0);
    cycle(32'h0, '0, 1'b0, 1'b1, 3, 16'hDEAD, 1'b1);
    cycle(mk(6'h21, 0, 3, 9, 0), 16'h10, 1'b0, 1'b0, 0, '0, 1'b0);
    n_tests++;
    if (bus.A3 !== e_a || bus.B3 !== e_b || bus.A3 === 16'hDEAD) begin
      n_fail++; $display("FAIL reset_keeps_rf got a=%h b=%h exp a=%h b=%h", bus.A3, bus.B3, e_a, e_b);
    end
  endtask

  task automatic test_issue();
    cycle(32'h0, '0, 1'b0, 1'b1, 3, 16'h1234, 1'b0);
    cycle(mk(6'h01, 5, 3, 0, 0), 16'h0040, 1'b0, 1'b0, 0, '0, 1'b0);
    n_tests++;
    if ({bus.OP3, bus.RD3, bus.WR3, bus.A3, bus.B3, bus.PC3} !==
        {6'h01, 4'd5, 1'b1, 16'h1234, 16'h0000, 16'h0040}) begin
      n_fail++; $display("FAIL issue_add got op=%h rd=%0d wr=%b a=%h b=%h pc=%h exp op=01 rd=5 wr=1 a=1234 b=0 pc=0040",
                         bus.OP3, bus.RD3, bus.WR3, bus.A3, bus.B3, bus.PC3);
    end
  endtask

  task automatic test_hazard();
    for (int k = 0; k < 3; k++) begin
      cycle(mk(6'h21, 0, 5, 0, 0), 16'h0041, 1'b0, 1'b0, 0, '0, 1'b0);
      n_tests++;
      if (got_stall !== 1'b1 || bus.OP3 !== 6'h00) begin
        n_fail++; $display("FAIL hazard_stall[%0d] got stall=%b op=%h exp stall=1 op=00", k, got_stall, bus.OP3);
      end
    end
    cycle(mk(6'h21, 0, 5, 0, 0), 16'h0041, 1'b0, 1'b1, 5, 16'hABCD, 1'b0);
    n_tests++;
    if (got_stall !== !FWD) begin
      n_fail++; $display("FAIL hazard_wb_cycle got stall=%b exp=%b", got_stall, !FWD);
    end
    if (!FWD) cycle(mk(6'h21, 0, 5, 0, 0), 16'h0041, 1'b0, 1'b0, 0, '0, 1'b0);
    n_tests++;
    if (got_stall !== 1'b0 || bus.OP3 !== 6'h21 || bus.A3 !== 16'hABCD) begin
      n_fail++; $display("FAIL hazard_release got stall=%b op=%h a=%h exp stall=0 op=21 a=abcd", got_stall, bus.OP3, bus.A3);
    end
  endtask

  task automatic test_flush();
    cycle(mk(6'h02, 5, 1, 2, 0), 16'h0050, 1'b0, 1'b0, 0, '0, 1'b0);
    cycle(mk(6'h22, 0, 5, 0, 0), 16'h0051, 1'b0, 1'b0, 0, '0, 1'b0);
    n_tests++;
    if (got_stall !== 1'b1) begin
      n_fail++; $display("FAIL flush_pre_stall got=%b exp=1", got_stall);
    end
    cycle(mk(6'h22, 0, 5, 0, 0), 16'h0051, 1'b1, 1'b0, 0, '0, 1'b0);
    n_tests++;
    if (got_stall !== 1'b0 || bus.OP3 !== 6'h00 || bus.PC3 !== '0) begin
      n_fail++; $display("FAIL flush_jmp got stall=%b op=%h pc=%h exp stall=0 op=00 pc=0", got_stall, bus.OP3, bus.PC3);
    end
    cycle(mk(6'h22, 0, 5, 0, 0), 16'h0060, 1'b0, 1'b0, 0, '0, 1'b0);
    n_tests++;
    if (got_stall !== 1'b1) begin
      n_fail++; $display("FAIL flush_busy_kept got stall=%b exp=1", got_stall);
    end
    cycle(32'h0, '0, 1'b0, 1'b1, 5, 16'h0F0F, 1'b0);
  endtask

  task automatic test_imm_r0();
    cycle(mk(6'h20, 0, 0, 0, 'h3FFF), 16'h0070, 1'b0, 1'b0, 0, '0, 1'b0);
    n_tests++;
    if (bus.IMM3 !== 16'hFFFF) begin
      n_fail++; $display("FAIL imm_neg got=%h exp=ffff", bus.IMM3);
    end
    cycle(mk(6'h20, 0, 0, 0, 'h1FFF), 16'h0071, 1'b0, 1'b0, 0, '0, 1'b0);
    n_tests++;
    if (bus.IMM3 !== 16'h1FFF) begin
      n_fail++; $display("FAIL imm_pos got=%h exp=1fff", bus.IMM3);
    end
    cycle(32'h0, '0, 1'b0, 1'b1, 0, 16'hBEEF, 1'b0);
    cycle(mk(6'h21, 0, 0, 0, 0), 16'h0072, 1'b0, 1'b0, 0, '0, 1'b0);
    n_tests++;
    if (bus.A3 !== 16'h0000 || bus.OP3 !== 6'h21) begin
      n_fail++; $display("FAIL r0_read got a=%h op=%h exp a=0000 op=21", bus.A3, bus.OP3);
    end
  endtask

  task automatic test_set_wins_and_clr();
    cycle(mk(6'h03, 7, 0, 0, 0), 16'h0080, 1'b0, 1'b1, 7, 16'h0005, 1'b0);
    cycle(mk(6'h23, 0, 7, 0, 0), 16'h0081, 1'b0, 1'b0, 0, '0, 1'b0);
    n_tests++;
    if (got_stall !== 1'b1) begin
      n_fail++; $display("FAIL set_wins got stall=%b exp=1", got_stall);
    end
    cycle(mk(6'h23, 0, 7, 0, 0), 16'h0081, 1'b0, 1'b0, 0, '0, 1'b1);
    n_tests++;
    if ({bus.OP3, bus.RD3, bus.WR3, bus.A3, bus.B3, bus.IMM3, bus.PC3} !== '0) begin
      n_fail++; $display("FAIL clr_in_stall got op=%h a=%h pc=%h exp all zero", bus.OP3, bus.A3, bus.PC3);
    end
    cycle(mk(6'h23, 0, 7, 0, 0), 16'h0082, 1'b0, 1'b0, 0, '0, 1'b0);
    n_tests++;
    if (got_stall !== 1'b0 || bus.OP3 !== 6'h23 || bus.PC3 !== 16'h0082) begin
      n_fail++; $display("FAIL after_clr got stall=%b op=%h pc=%h exp stall=0 op=23 pc=0082", got_stall, bus.OP3, bus.PC3);
    end
  endtask

  task automatic test_random();
    logic [31:0] ir;
    int op;
    ir = 32'h0;
    for (int n = 0; n < 400; n++) begin
      if (!(got_stall === 1'b1)) begin
        case ($urandom_range(3))
          0:       op = 0;
          1, 2:    op = int'($urandom_range(31, 1));
          default: op = int'($urandom_range(63, 32));
        endcase
        ir = mk(op, int'($urandom_range(7)), int'($urandom_range(7)),
                int'($urandom_range(7)), int'($urandom));
      end
      cycle(ir, DW'($urandom), ($urandom_range(9) == 0), ($urandom_range(99) < 35),
            int'($urandom_range(7)), DW'($urandom), ($urandom_range(49) == 0));
      n_tests++;
      if (got_stall !== exp_stall ||
          {bus.OP3, bus.RD3, bus.WR3, bus.A3, bus.B3, bus.IMM3, bus.PC3} !==
          {e_op, e_rd, e_wr, e_a, e_b, e_imm, e_pc}) begin
        n_fail++;
        $display("FAIL random[%0d] got stall=%b op=%h rd=%0d wr=%b a=%h b=%h imm=%h pc=%h exp stall=%b op=%h rd=%0d wr=%b a=%h b=%h imm=%h pc=%h",
                 n, got_stall, bus.OP3, bus.RD3, bus.WR3, bus.A3, bus.B3, bus.IMM3, bus.PC3,
                 exp_stall, e_op, e_rd, e_wr, e_a, e_b, e_imm, e_pc);
      end
    end
  endtask

  initial begin
    bus.IR2 = '0; bus.PC2 = '0; bus.jmp = 1'b0;
    bus.wb_en = 1'b0; bus.wb_addr = '0; bus.wb_data = '0; clr = 1'b1;
    foreach (m_busy[i]) m_busy[i] = 1'b0;
    got_stall = 1'b0;
    #1;
    test_reset();
    test_issue();
    test_hazard();
    test_flush();
    test_imm_r0();
    test_set_wins_and_clr();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete, got timeout exp finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 Parameter: DW, 16, data/address width of registers, operands and PC.
REQ-002 Port: clk  in  1  clock; all state updates on rising edge.
REQ-003 Port: clr  in  1  clear; reset is synchronous and active-high.
REQ-004 Port: IR2  in  32  instruction from IF stage.
REQ-005 Port: PC2  in  DW  PC+1 of IR2, from IF stage.
REQ-006 Port: jmp  in  1  taken jump in EX; squash instruction in ID.
REQ-007 Port: wb_en  in  1  register-file write enable from WB stage.
REQ-008 Port: wb_addr  in  4  write register index.
REQ-009 Port: wb_data  in  DW  write data.
REQ-010 Port: stall  out  1  combinational; IF holds PC1 and IR2 while high.
REQ-011 Ports to EX, all registered: OP3 out 6; RD3 out 4; WR3 out 1 (writes rd); A3, B3, IMM3, PC3 out DW each.

Function
REQ-012 Fields: opcode=IR2[31:26], rd=IR2[25:22], ra=IR2[21:18], rb=IR2[17:14], imm=IR2[13:0] sign-extended to DW.
REQ-013 Writes-rd rule: opcode 0x01-0x1F write rd; 0x00 (NOP) and 0x20-0x3F do not; rd=0 never counts as a write.
REQ-014 Register file: 16 x DW; r0 reads 0 and ignores writes; write at clk edge when wb_en.
REQ-015 Scoreboard: 16 busy bits; set busy[rd] on issue of a writes-rd instruction; clear busy[wb_addr] on wb_en; same-register set and clear in one cycle -> set wins.
REQ-016 Hazard: stall=1 when ra or rb of a non-NOP instruction has busy=1 (subject to REQ-026), and jmp=0.
REQ-017 Issue: jmp=0 and stall=0 -> output registers load decoded fields, A3/B3 = register reads, PC3=PC2, WR3 per REQ-013; latency one cycle.
REQ-018 Bubble: stall=1 -> output registers load NOP (all fields 0); scoreboard not set.
REQ-019 Flush: jmp=1 -> output registers load NOP; scoreboard not set; stall forced 0; jmp overrides stall.
REQ-020 Writeback clear is independent of stall/flush; it happens every cycle wb_en=1.
REQ-021 Write to a register is visible to a read in the next cycle regardless of configuration.

Reset
REQ-022 clr=1 at edge: all output registers 0, all busy bits 0; register file contents unchanged except r0=0.
REQ-023 clr overrides jmp, stall and wb_en in the same cycle; a wb_en write coincident with clr is discarded.
REQ-024 clr mid-stall: stall is 0 the cycle after clr, because all busy bits are cleared.

Configuration
REQ-025 Macro ID_FORWARD_EN selects WB bypass.
REQ-026 Defined: a read of register X in the cycle wb_en=1 and wb_addr=X returns wb_data; busy[X] counts as clear for REQ-016 in that cycle.
REQ-027 Undefined: the same-cycle read returns the old value and stall stays 1 that cycle; the stall ends in the cycle after writeback.

Structure
REQ-028 Package id_pkg holds: opcode field positions; OP_NOP=6'h00; writes-rd predicate function; the decoded-instruction struct used for the EX output register.
REQ-029 Sub-module id_regfile holds the 16 x DW array, two read ports, one write port and the r0 rule; the scoreboard and output register stay in id_stage.

Verification
REQ-030 clr, then wb r3<=0x1234; issue ADD-class op=0x01 rd=5 ra=3 rb=0 -> next cycle OP3=0x01, RD3=5, A3=0x1234, B3=0, WR3=1.
REQ-031 Issue rd=5 writer, then reader ra=5 -> stall=1 and OP3=0 each stalled cycle; wb r5 -> stall drops same cycle (FORWARD_EN) or one cycle later (without); A3=wb_data.
REQ-032 jmp=1 while stalled on r5 -> stall=0, OP3=0 next cycle, busy[5] still 1 until wb.
REQ-033 Issue imm=14'h3FFF -> IMM3=0xFFFF; imm=14'h1FFF -> IMM3=0x1FFF; wb r0<=0xBEEF then read r0 -> 0.
REQ-034 Writer to r7 issues in the same cycle wb clears r7 -> busy[7]=1 after edge; clr during stall -> all outputs 0, stall=0 next cycle.
